// File: rtl/rs_dispatch.sv
// Issue-side driver for the ALU reservation station: a single-entry holding
// register that snoops result broadcasts, pushes into a free slot and pops ready entries.
module rs_dispatch #(
  parameter int OP_W   = 6,
  parameter int IMM_W  = 32,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 4,
  parameter int RS_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ready,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ROB_W-1:0]  in_robpos,
  input  logic [DATA_W-1:0] in_vj,
  input  logic [DATA_W-1:0] in_vk,
  input  logic              in_qj,
  input  logic              in_qk,
  input  logic              alu_in_flag,
  input  logic [DATA_W-1:0] alu_val,
  input  logic [ROB_W-1:0]  alu_robpos,
  input  logic              lsb_in_flag,
  input  logic [DATA_W-1:0] lsb_val,
  input  logic [ROB_W-1:0]  lsb_robpos,
  output logic              getpos,
  input  logic              rs_full,
  input  logic              rs_avail,
  input  logic [RS_W-1:0]   rs_avail_pos,
  output logic              push,
  output logic [RS_W-1:0]   push_pos,
  output logic [OP_W-1:0]   push_op,
  output logic [IMM_W-1:0]  push_imm,
  output logic [ADDR_W-1:0] push_pc,
  output logic [ROB_W-1:0]  push_robpos,
  output logic [DATA_W-1:0] push_vj,
  output logic              push_qj,
  output logic [DATA_W-1:0] push_vk,
  output logic              push_qk,
  input  logic              rs_ready,
  input  logic [RS_W-1:0]   rs_ready_pos,
  input  logic              alu_busy,
  output logic              front,
  output logic [RS_W-1:0]   front_pos,
  output logic [31:0]       stall_cnt
);

  // Resolve one operand against both broadcasts; ALU wins a simultaneous match.
  // Returns {q, v}.
  function automatic logic [DATA_W:0] snoop(
    input logic [DATA_W-1:0] v,
    input logic              q,
    input logic              a_flag,
    input logic [ROB_W-1:0]  a_pos,
    input logic [DATA_W-1:0] a_val,
    input logic              l_flag,
    input logic [ROB_W-1:0]  l_pos,
    input logic [DATA_W-1:0] l_val
  );
    logic [DATA_W:0] res;
    if (q && a_flag && (v[ROB_W-1:0] == a_pos)) begin
      res = {1'b0, a_val};
    end else if (q && l_flag && (v[ROB_W-1:0] == l_pos)) begin
      res = {1'b0, l_val};
    end else begin
      res = {q, v};
    end
    return res;
  endfunction

  logic              hold_valid_r;
  logic [OP_W-1:0]   op_r;
  logic [IMM_W-1:0]  imm_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ROB_W-1:0]  robpos_r;
  logic [DATA_W-1:0] vj_r;
  logic              qj_r;
  logic [DATA_W-1:0] vk_r;
  logic              qk_r;
  logic [31:0]       stall_cnt_r;

  logic              en_s;
  logic              push_s;
  logic              in_ready_s;
  logic              capture_s;
  logic [DATA_W-1:0] src_vj_s;
  logic              src_qj_s;
  logic [DATA_W-1:0] src_vk_s;
  logic              src_qk_s;
  logic [DATA_W:0]   j_snp_s;
  logic [DATA_W:0]   k_snp_s;

  // Handshake decode; every strobe is forced low while reset is asserted.
  always_comb begin
    en_s       = reset & ready & ~clear;
    push_s     = en_s & hold_valid_r & rs_avail & ~rs_full;
    in_ready_s = en_s & (~hold_valid_r | push_s);
    capture_s  = in_valid & in_ready_s;
  end

  // Snoop either the incoming instruction or the held one, whichever will be kept.
  always_comb begin
    if (capture_s) begin
      src_vj_s = in_vj;
      src_qj_s = in_qj;
      src_vk_s = in_vk;
      src_qk_s = in_qk;
    end else begin
      src_vj_s = vj_r;
      src_qj_s = qj_r;
      src_vk_s = vk_r;
      src_qk_s = qk_r;
    end
    j_snp_s = snoop(src_vj_s, src_qj_s, alu_in_flag, alu_robpos, alu_val,
                    lsb_in_flag, lsb_robpos, lsb_val);
    k_snp_s = snoop(src_vk_s, src_qk_s, alu_in_flag, alu_robpos, alu_val,
                    lsb_in_flag, lsb_robpos, lsb_val);
  end

  // Holding register: capture, release on push, or refresh operands while waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_valid_r <= 1'b0;
      op_r         <= {OP_W{1'b0}};
      imm_r        <= {IMM_W{1'b0}};
      pc_r         <= {ADDR_W{1'b0}};
      robpos_r     <= {ROB_W{1'b0}};
      vj_r         <= {DATA_W{1'b0}};
      qj_r         <= 1'b0;
      vk_r         <= {DATA_W{1'b0}};
      qk_r         <= 1'b0;
    end else if (ready) begin
      if (clear) begin
        hold_valid_r <= 1'b0;
      end else if (capture_s) begin
        hold_valid_r <= 1'b1;
        op_r         <= in_op;
        imm_r        <= in_imm;
        pc_r         <= in_pc;
        robpos_r     <= in_robpos;
        vj_r         <= j_snp_s[DATA_W-1:0];
        qj_r         <= j_snp_s[DATA_W];
        vk_r         <= k_snp_s[DATA_W-1:0];
        qk_r         <= k_snp_s[DATA_W];
      end else if (push_s) begin
        // The RS snoops the pushed entry itself, so the stale copy is left alone.
        hold_valid_r <= 1'b0;
      end else if (hold_valid_r) begin
        vj_r <= j_snp_s[DATA_W-1:0];
        qj_r <= j_snp_s[DATA_W];
        vk_r <= k_snp_s[DATA_W-1:0];
        qk_r <= k_snp_s[DATA_W];
      end else begin
        hold_valid_r <= 1'b0;
      end
    end else begin
      hold_valid_r <= hold_valid_r;
    end
  end

  // Count enabled cycles in which a held instruction could not be pushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 32'd0;
    end else if (en_s && hold_valid_r && !push_s) begin
      stall_cnt_r <= stall_cnt_r + 32'd1;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Output drive; RS-facing fields come straight from the holding register.
  always_comb begin
    in_ready    = in_ready_s;
    getpos      = reset & hold_valid_r & ~clear;
    push        = push_s;
    push_pos    = rs_avail_pos;
    push_op     = op_r;
    push_imm    = imm_r;
    push_pc     = pc_r;
    push_robpos = robpos_r;
    push_vj     = vj_r;
    push_qj     = qj_r;
    push_vk     = vk_r;
    push_qk     = qk_r;
    front       = en_s & rs_ready & ~alu_busy;
    front_pos   = rs_ready_pos;
    stall_cnt   = stall_cnt_r;
  end

endmodule

// File: tb/tb_rs_dispatch.sv
// Directed self-checking bench for rs_dispatch: handshake, stall counting,
// operand snooping, front selection, clear and asynchronous reset.
module tb_rs_dispatch;

  logic        clk = 1'b0;
  logic        reset, ready, clear, in_valid, in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_imm, in_pc, in_vj, in_vk;
  logic [3:0]  in_robpos;
  logic        in_qj, in_qk;
  logic        alu_in_flag, lsb_in_flag;
  logic [31:0] alu_val, lsb_val;
  logic [3:0]  alu_robpos, lsb_robpos;
  logic        getpos, rs_full, rs_avail, push;
  logic [3:0]  rs_avail_pos, push_pos, push_robpos;
  logic [5:0]  push_op;
  logic [31:0] push_imm, push_pc, push_vj, push_vk;
  logic        push_qj, push_qk;
  logic        rs_ready, alu_busy, front;
  logic [3:0]  rs_ready_pos, front_pos;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rs_dispatch dut (
    .clk(clk), .reset(reset), .ready(ready), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_imm(in_imm), .in_pc(in_pc), .in_robpos(in_robpos),
    .in_vj(in_vj), .in_vk(in_vk), .in_qj(in_qj), .in_qk(in_qk),
    .alu_in_flag(alu_in_flag), .alu_val(alu_val), .alu_robpos(alu_robpos),
    .lsb_in_flag(lsb_in_flag), .lsb_val(lsb_val), .lsb_robpos(lsb_robpos),
    .getpos(getpos), .rs_full(rs_full), .rs_avail(rs_avail), .rs_avail_pos(rs_avail_pos),
    .push(push), .push_pos(push_pos), .push_op(push_op), .push_imm(push_imm),
    .push_pc(push_pc), .push_robpos(push_robpos), .push_vj(push_vj), .push_qj(push_qj),
    .push_vk(push_vk), .push_qk(push_qk),
    .rs_ready(rs_ready), .rs_ready_pos(rs_ready_pos), .alu_busy(alu_busy),
    .front(front), .front_pos(front_pos), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one cycle; inputs change just after the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [5:0] op, input logic [3:0] rob,
                       input logic [31:0] vj, input logic qj,
                       input logic [31:0] vk, input logic qk);
    in_valid  = 1'b1;
    in_op     = op;
    in_robpos = rob;
    in_imm    = {26'd0, op} + 32'h100;
    in_pc     = {28'd0, rob} << 2;
    in_vj     = vj;
    in_qj     = qj;
    in_vk     = vk;
    in_qk     = qk;
  endtask

  initial begin
    reset = 1'b0; ready = 1'b1; clear = 1'b0; in_valid = 1'b0;
    in_op = 6'd0; in_imm = 32'd0; in_pc = 32'd0; in_robpos = 4'd0;
    in_vj = 32'd0; in_vk = 32'd0; in_qj = 1'b0; in_qk = 1'b0;
    alu_in_flag = 1'b0; alu_val = 32'd0; alu_robpos = 4'd0;
    lsb_in_flag = 1'b0; lsb_val = 32'd0; lsb_robpos = 4'd0;
    rs_full = 1'b0; rs_avail = 1'b0; rs_avail_pos = 4'd0;
    rs_ready = 1'b1; rs_ready_pos = 4'd0; alu_busy = 1'b0;

    // Reset state: strobes gated even though ready=1 and rs_ready=1
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_front", front, 0);
    check("rst_push", push, 0);
    check("rst_stall", stall_cnt, 0);
    tick();
    reset = 1'b1;
    rs_ready = 1'b0;
    #1;

    // Basic capture then push
    offer(6'd3, 4'd5, 32'h11, 1'b0, 32'h22, 1'b0);
    rs_avail = 1'b1; rs_avail_pos = 4'd2;
    #1;
    check("t1_in_ready", in_ready, 1);
    check("t1_push_c0", push, 0);
    check("t1_getpos_c0", getpos, 0);
    tick();
    in_valid = 1'b0;
    #1;
    check("t1_push", push, 1);
    check("t1_push_pos", push_pos, 2);
    check("t1_push_robpos", push_robpos, 5);
    check("t1_push_op", push_op, 3);
    check("t1_push_vk", push_vk, 32'h22);
    check("t1_getpos", getpos, 1);
    tick();
    check("t1_drained_push", push, 0);
    check("t1_drained_getpos", getpos, 0);
    check("t1_stall", stall_cnt, 0);

    // Stall with no free slot
    offer(6'd4, 4'd6, 32'h0, 1'b0, 32'h0, 1'b0);
    rs_avail = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_stall_push", push, 0);
      check("t2_stall_in_ready", in_ready, 0);
      tick();
    end
    check("t2_stall_cnt", stall_cnt, 4);

    // Slot frees: push B and accept C in the same cycle
    rs_avail = 1'b1; rs_avail_pos = 4'd9;
    offer(6'd5, 4'd8, 32'd7, 1'b1, 32'h33, 1'b0);
    #1;
    check("t2_push", push, 1);
    check("t2_in_ready", in_ready, 1);
    check("t2_push_op_b", push_op, 4);
    check("t2_push_pos", push_pos, 9);
    tick();
    in_valid = 1'b0; rs_avail = 1'b0;
    #1;
    check("t2_stall_after", stall_cnt, 4);
    check("t3_held_op", push_op, 5);
    check("t3_held_qj", push_qj, 1);
    check("t3_held_vj", push_vj, 7);

    // ALU and LSB both match tag 7; ALU must win
    alu_in_flag = 1'b1; alu_robpos = 4'd7; alu_val = 32'hDEADBEEF;
    lsb_in_flag = 1'b1; lsb_robpos = 4'd7; lsb_val = 32'h55;
    tick();
    alu_in_flag = 1'b0; lsb_in_flag = 1'b0;
    #1;
    check("t3_snoop_vj", push_vj, 32'hDEADBEEF);
    check("t3_snoop_qj", push_qj, 0);
    check("t3_stall", stall_cnt, 5);

    // Push C while capturing D with a same-cycle LSB match on k; ALU tag 9
    // matches vj's low bits but qj=0 so vj must stay put
    rs_avail = 1'b1;
    offer(6'd6, 4'd1, 32'h99, 1'b0, 32'd3, 1'b1);
    lsb_in_flag = 1'b1; lsb_robpos = 4'd3; lsb_val = 32'h10;
    alu_in_flag = 1'b1; alu_robpos = 4'd9; alu_val = 32'hAAAA;
    #1;
    check("t4_push_c", push, 1);
    tick();
    in_valid = 1'b0; rs_avail = 1'b0; lsb_in_flag = 1'b0; alu_in_flag = 1'b0;
    #1;
    check("t4_capture_vk", push_vk, 32'h10);
    check("t4_capture_qk", push_qk, 0);
    check("t4_vj_untouched", push_vj, 32'h99);
    check("t4_op", push_op, 6);
    check("t4_stall", stall_cnt, 5);

    // Front selection
    rs_ready = 1'b1; rs_ready_pos = 4'd6; alu_busy = 1'b1;
    #1;
    check("t5_front_busy", front, 0);
    alu_busy = 1'b0;
    #1;
    check("t5_front", front, 1);
    check("t5_front_pos", front_pos, 6);

    // ready=0 freezes everything and blocks all strobes
    ready = 1'b0; rs_avail = 1'b1;
    #1;
    check("t5_nr_front", front, 0);
    check("t5_nr_push", push, 0);
    check("t5_nr_in_ready", in_ready, 0);
    tick();
    check("t5_nr_stall", stall_cnt, 5);
    check("t5_nr_getpos", getpos, 1);
    ready = 1'b1;

    // Clear while holding
    clear = 1'b1;
    #1;
    check("t6_clr_push", push, 0);
    check("t6_clr_getpos", getpos, 0);
    check("t6_clr_front", front, 0);
    check("t6_clr_in_ready", in_ready, 0);
    tick();
    clear = 1'b0;
    #1;
    check("t6_after_getpos", getpos, 0);
    check("t6_after_push", push, 0);
    check("t6_after_in_ready", in_ready, 1);
    check("t6_after_stall", stall_cnt, 5);

    // Async reset in the middle of a hold
    rs_avail = 1'b0;
    offer(6'd7, 4'd2, 32'h44, 1'b0, 32'h45, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    check("t7_pre_stall", stall_cnt, 6);
    check("t7_pre_getpos", getpos, 1);
    #2;
    reset = 1'b0;
    #1;
    check("t7_rst_getpos", getpos, 0);
    check("t7_rst_front", front, 0);
    check("t7_rst_in_ready", in_ready, 0);
    check("t7_rst_stall", stall_cnt, 0);
    check("t7_rst_op", push_op, 0);
    check("t7_rst_vj", push_vj, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
